// File: rtl/dmg_lcd_pkg.sv
// Shared DMG LCD definitions: default panel timing, framebuffer address width
// and the 2-bit pixel type used by both the transmitter and gbreader.
package dmg_lcd_pkg;

    localparam int unsigned H_ACTIVE  = 160;
    localparam int unsigned V_ACTIVE  = 144;
    localparam int unsigned H_TOTAL   = 456;
    localparam int unsigned V_TOTAL   = 154;
    localparam int unsigned H_START   = 8;
    localparam int unsigned HS_WIDTH  = 4;
    localparam int unsigned VS_LINES  = 1;
    localparam int unsigned FB_ADDR_W = 15;

    typedef logic [1:0] pixel_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } tx_state_t;

endpackage

// File: rtl/dmg_timing_gen.sv
// DMG line/frame timing: IDLE/RUN sequencing, hcnt/vcnt, registered syncs
// and the combinational framebuffer fetch window.
module dmg_timing_gen #(
    parameter int unsigned H_ACTIVE = dmg_lcd_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = dmg_lcd_pkg::V_ACTIVE,
    parameter int unsigned H_TOTAL  = dmg_lcd_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL  = dmg_lcd_pkg::V_TOTAL,
    parameter int unsigned H_START  = dmg_lcd_pkg::H_START,
    parameter int unsigned HS_WIDTH = dmg_lcd_pkg::HS_WIDTH,
    parameter int unsigned VS_LINES = dmg_lcd_pkg::VS_LINES,
    parameter int unsigned HCNT_W   = $clog2(H_TOTAL),
    parameter int unsigned VCNT_W   = $clog2(V_TOTAL)
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic run,
    output logic frame_origin,
    output logic fetch,
    output logic hs,
    output logic vs,
    output logic frame_start,
    output logic busy
);
    import dmg_lcd_pkg::*;

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [HCNT_W-1:0]  hcnt;
    logic [VCNT_W-1:0]  vcnt;
    logic               line_end;
    logic               frame_end;
    logic               hs_c;
    logic               vs_c;

    assign line_end  = (hcnt == HCNT_W'(H_TOTAL - 1));
    assign frame_end = line_end && (vcnt == VCNT_W'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // enable only matters on the last cycle of a frame (or while idle)
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_RUN;
            ST_RUN:  if (frame_end && !enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        run          = (state == ST_RUN);
        frame_origin = run && (hcnt == '0) && (vcnt == '0);
        hs_c         = run && (hcnt < HCNT_W'(HS_WIDTH));
        vs_c         = run && (vcnt < VCNT_W'(VS_LINES));
        fetch        = run && (vcnt < VCNT_W'(V_ACTIVE))
                           && (hcnt >= HCNT_W'(H_START - 1))
                           && (hcnt <  HCNT_W'(H_START - 1 + H_ACTIVE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (state != ST_RUN) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (line_end) begin
            hcnt <= '0;
            vcnt <= frame_end ? '0 : vcnt + VCNT_W'(1);
        end else begin
            hcnt <= hcnt + HCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs          <= 1'b0;
            vs          <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hs          <= hs_c;
            vs          <= vs_c;
            frame_start <= frame_origin;
            busy        <= run;
        end
    end

endmodule

// File: rtl/dmg_lcd_tx.sv
// DMG LCD stream transmitter: walks a 2bpp framebuffer linearly and drives
// hs/vs/d0/d1 with DMG line/frame timing, one pixel per clk.
module dmg_lcd_tx #(
    parameter int unsigned H_ACTIVE = dmg_lcd_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = dmg_lcd_pkg::V_ACTIVE,
    parameter int unsigned H_TOTAL  = dmg_lcd_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL  = dmg_lcd_pkg::V_TOTAL,
    parameter int unsigned H_START  = dmg_lcd_pkg::H_START,
    parameter int unsigned HS_WIDTH = dmg_lcd_pkg::HS_WIDTH,
    parameter int unsigned VS_LINES = dmg_lcd_pkg::VS_LINES,
    parameter int unsigned ADDR_W   = dmg_lcd_pkg::FB_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic                fb_rd,
    input  dmg_lcd_pkg::pixel_t fb_q,
    output logic                hs,
    output logic                vs,
    output logic                d0,
    output logic                d1,
    output logic                frame_start,
    output logic                busy
);
    import dmg_lcd_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    if (H_ACTIVE * V_ACTIVE > 2 ** ADDR_W) begin : g_addr_chk
        $error("dmg_lcd_tx: H_ACTIVE*V_ACTIVE does not fit in ADDR_W");
    end
    if (H_START < 1 || H_START < HS_WIDTH) begin : g_start_chk
        $error("dmg_lcd_tx: H_START must be >= 1 and >= HS_WIDTH");
    end
    if (H_START - 1 + H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL) begin : g_window_chk
        $error("dmg_lcd_tx: active window exceeds line/frame totals");
    end

    logic   run;
    logic   frame_origin;
    logic   fetch_d1;
    pixel_t pix_q;

    dmg_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .H_START  (H_START),
        .HS_WIDTH (HS_WIDTH),
        .VS_LINES (VS_LINES)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .run          (run),
        .frame_origin (frame_origin),
        .fetch        (fb_rd),
        .hs           (hs),
        .vs           (vs),
        .frame_start  (frame_start),
        .busy         (busy)
    );

    // Saturates on the last pixel so the final address is held through vblank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_addr <= '0;
        end else if (!run || frame_origin) begin
            fb_addr <= '0;
        end else if (fb_rd && fb_addr != ADDR_LAST) begin
            fb_addr <= fb_addr + ADDR_W'(1);
        end
    end

    // fb_q belongs to the previous cycle's fetch; mask it outside the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_d1 <= 1'b0;
            pix_q    <= '0;
        end else begin
            fetch_d1 <= fb_rd;
            pix_q    <= fetch_d1 ? fb_q : '0;
        end
    end

    assign d1 = pix_q[1];
    assign d0 = pix_q[0];

endmodule

// File: tb/tb_dmg_lcd_tx.sv
// Directed bench for dmg_lcd_tx on a reduced 10x6 panel (24x9 totals) so that
// several complete frames run in a few thousand cycles.
module tb_dmg_lcd_tx;

    localparam int unsigned HA    = 10;
    localparam int unsigned VA    = 6;
    localparam int unsigned HT    = 24;
    localparam int unsigned VT    = 9;
    localparam int unsigned HSTRT = 4;
    localparam int unsigned HSW   = 3;
    localparam int unsigned VSL   = 2;
    localparam int unsigned AW    = 6;
    localparam int unsigned FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] fb_addr;
    logic          fb_rd;
    logic [1:0]    fb_q = 2'b00;
    logic          hs, vs, d0, d1, frame_start, busy;

    dmg_lcd_tx #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .H_START  (HSTRT),
        .HS_WIDTH (HSW),
        .VS_LINES (VSL),
        .ADDR_W   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fb_addr     (fb_addr),
        .fb_rd       (fb_rd),
        .fb_q        (fb_q),
        .hs          (hs),
        .vs          (vs),
        .d0          (d0),
        .d1          (d1),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // synchronous framebuffer: pixel value is the low two address bits
    always @(posedge clk) fb_q <= fb_addr[1:0];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int unsigned cyc, fs_cyc, fs_gap, fs_cnt, busy_cnt, rd_cnt, addr_err;
    int unsigned hs_cycles, hs_rises, vs_cycles, vs_first, vs_last;
    int unsigned p, exp_addr, last_addr;
    logic        hs_prev, vs_prev;
    logic [1:0]  pix [FRAME];
    logic [AW-1:0] addr_log [FRAME];

    task automatic clear_stats();
        fs_cnt = 0; fs_gap = 0; busy_cnt = 0; rd_cnt = 0; addr_err = 0;
        hs_cycles = 0; hs_rises = 0; vs_cycles = 0; vs_first = 9999; vs_last = 9999;
        p = 100000; exp_addr = 0; last_addr = 9999; hs_prev = 1'b0; vs_prev = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            pix[i] = 2'b11;
            addr_log[i] = '1;
        end
    endtask

    // p counts cycles since the most recent frame_start pulse
    task automatic watch(input int unsigned n, input int unsigned drop_fs, input int unsigned drop_p);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (frame_start) begin
                fs_cnt++;
                if (fs_cnt > 1) fs_gap = cyc - fs_cyc;
                fs_cyc = cyc;
                p = 0;
                exp_addr = 0;
            end else begin
                p++;
            end
            if (busy) busy_cnt++;
            if (fb_rd) begin
                if (32'(fb_addr) != exp_addr) addr_err++;
                last_addr = 32'(fb_addr);
                exp_addr++;
                rd_cnt++;
            end
            if (hs) begin
                hs_cycles++;
                if (!hs_prev) hs_rises++;
            end
            hs_prev = hs;
            if (vs) begin
                vs_cycles++;
                vs_last = p;
                if (!vs_prev) vs_first = p;
            end
            vs_prev = vs;
            if (fs_cnt == 1 && p < FRAME) begin
                pix[p] = {d1, d0};
                addr_log[p] = fb_addr;
            end
            if (fs_cnt == drop_fs && p == drop_p) enable = 1'b0;
        end
    endtask

    initial begin
        cyc = 0;
        fs_cyc = 0;
        clear_stats();

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {25'd0, hs, vs, d1, d0, fb_rd, busy, frame_start}, 32'd0);
        check("reset_addr", 32'(fb_addr), 32'd0);

        // single frame from a 1-cycle enable pulse
        clear_stats();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        watch(300, 0, 0);
        check("single_fs_count", fs_cnt, 1);
        check("single_busy_cycles", busy_cnt, FRAME);
        check("single_rd_count", rd_cnt, HA * VA);
        check("single_addr_order", addr_err, 0);
        check("single_last_addr", last_addr, HA * VA - 1);
        check("single_hs_pulses", hs_rises, VT);
        check("single_hs_cycles", hs_cycles, VT * HSW);
        check("single_vs_first", vs_first, 0);
        check("single_vs_last", vs_last, VSL * HT - 1);
        check("single_vs_cycles", vs_cycles, VSL * HT);
        check("pix_h3", 32'(pix[3]), 0);
        check("pix_h4", 32'(pix[4]), 0);
        check("pix_h5", 32'(pix[5]), 1);
        check("pix_h6", 32'(pix[6]), 2);
        check("pix_h7", 32'(pix[7]), 3);
        check("pix_h13_last", 32'(pix[13]), 1);
        check("pix_h14_after", 32'(pix[14]), 0);
        check("pix_line1_first", 32'(pix[HT + 4]), 2);
        check("pix_line5_last", 32'(pix[5 * HT + 13]), 3);
        check("pix_vblank", 32'(pix[6 * HT + 4]), 0);
        check("addr_hold_vblank", 32'(addr_log[7 * HT]), HA * VA - 1);
        check("idle_addr", 32'(fb_addr), 0);
        check("idle_busy", 32'(busy), 0);

        // asynchronous reset in the middle of a fetch
        enable = 1'b1;
        repeat (6) @(negedge clk);
        check("prerst_fb_rd", 32'(fb_rd), 1);
        check("prerst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {25'd0, hs, vs, d1, d0, fb_rd, busy, frame_start}, 32'd0);
        check("midrst_addr", 32'(fb_addr), 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_stats();
        watch(50, 0, 0);
        check("postrst_busy", busy_cnt, 0);
        check("postrst_fs", fs_cnt, 0);
        check("postrst_hs", hs_cycles, 0);

        // enable dropped mid-frame: frame still completes
        clear_stats();
        enable = 1'b1;
        watch(300, 1, 4 * HT + 10);
        check("drop_fs_count", fs_cnt, 1);
        check("drop_busy_cycles", busy_cnt, FRAME);
        check("drop_rd_count", rd_cnt, HA * VA);

        // held enable, dropped on the last cycle of frame 2 -> two frames
        clear_stats();
        enable = 1'b1;
        watch(2 * FRAME + 80, 2, FRAME - 2);
        check("b2b_fs_count", fs_cnt, 2);
        check("b2b_fs_gap", fs_gap, FRAME);
        check("b2b_busy_cycles", busy_cnt, 2 * FRAME);
        check("b2b_rd_count", rd_cnt, 2 * HA * VA);
        check("b2b_addr_order", addr_err, 0);

        // dropped one cycle after frame 1's last cycle -> frame 2 still runs
        clear_stats();
        enable = 1'b1;
        watch(2 * FRAME + 80, 1, FRAME - 1);
        check("late_drop_fs_count", fs_cnt, 2);
        check("late_drop_fs_gap", fs_gap, FRAME);
        check("late_drop_busy", busy_cnt, 2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
